// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bram_port_arbiter
// Purpose : Arbitrates the single-port data BRAM between CPU and video fetch,
//           tagging reads so the returning data reaches the requester that issued it.
// Revision: 1.0
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int READ_LAT      = 1,
    parameter int PRIORITY_MODE = 0,
    parameter int VID_MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_q
);

    localparam int WAIT_W = (VID_MAX_WAIT < 1) ? 1 : $clog2(VID_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(VID_MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

    owner_e              last_owner_q, last_owner_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [READ_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [READ_LAT-1:0] tag_vid_q, tag_vid_d;
    logic                cpu_win, vid_win;

    always_comb begin
        cpu_win = 1'b0;
        vid_win = 1'b0;
        if (!reset) begin
            if (cpu_req && !vid_req) begin
                cpu_win = 1'b1;
            end else if (vid_req && !cpu_req) begin
                vid_win = 1'b1;
            end else if (cpu_req && vid_req) begin
                // Mode 0: CPU first unless video has starved; mode 1: alternate.
                if (PRIORITY_MODE == 0) begin
                    vid_win = (wait_cnt_q == WAIT_MAX);
                end else begin
                    vid_win = (last_owner_q == OWN_CPU);
                end
                cpu_win = ~vid_win;
            end
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (cpu_win) begin
            last_owner_d = OWN_CPU;
        end else if (vid_win) begin
            last_owner_d = OWN_VID;
        end

        wait_cnt_d = wait_cnt_q;
        if (!vid_req || vid_win) begin
            wait_cnt_d = '0;
        end else if (cpu_win && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        // Writes enter the pipe as invalid so they never produce rvalid.
        tag_valid_d    = tag_valid_q;
        tag_vid_d      = tag_vid_q;
        tag_valid_d[0] = cpu_win ? ~cpu_we : vid_win;
        tag_vid_d[0]   = vid_win;
        for (int i = 1; i < READ_LAT; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_vid_d[i]   = tag_vid_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner_q <= OWN_IDLE;
            wait_cnt_q   <= '0;
            tag_valid_q  <= '0;
            tag_vid_q    <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
            tag_valid_q  <= tag_valid_d;
            tag_vid_q    <= tag_vid_d;
        end
    end

    assign cpu_gnt    = cpu_win;
    assign vid_gnt    = vid_win;
    assign bram_we    = cpu_win & cpu_we;
    assign bram_addr  = cpu_win ? cpu_addr : (vid_win ? vid_addr : '0);
    assign bram_wdata = cpu_win ? cpu_wdata : '0;
    assign cpu_rvalid = tag_valid_q[READ_LAT-1] & ~tag_vid_q[READ_LAT-1];
    assign vid_rvalid = tag_valid_q[READ_LAT-1] &  tag_vid_q[READ_LAT-1];
    assign cpu_rdata  = bram_q;
    assign vid_rdata  = bram_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bram_port_arbiter
// Purpose : Self-checking bench: three arbiter configurations against a
//           rule-level model plus directed literal expectations.
// Revision: 1.0
// ============================================================================
module tb_bram_port_arbiter;

    // Instance 0: mode 0, latency 1. Instance 1: mode 1, latency 1. Instance 2: mode 0, latency 3.
    localparam int N = 3;

    logic        clk;
    logic        rst_a      [N];
    logic        cpu_req    [N];
    logic        cpu_we     [N];
    logic [15:0] cpu_addr   [N];
    logic [15:0] cpu_wdata  [N];
    logic        cpu_gnt    [N];
    logic        cpu_rvalid [N];
    logic [15:0] cpu_rdata  [N];
    logic        vid_req    [N];
    logic [15:0] vid_addr   [N];
    logic        vid_gnt    [N];
    logic        vid_rvalid [N];
    logic [15:0] vid_rdata  [N];
    logic [15:0] bram_addr  [N];
    logic [15:0] bram_wdata [N];
    logic        bram_we    [N];
    logic [15:0] bram_q     [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        logic [15:0] mem [65536];
        logic [15:0] qp  [3];

        bram_port_arbiter #(
            .ADDR_W(16), .DATA_W(16), .READ_LAT(LAT),
            .PRIORITY_MODE((g == 1) ? 1 : 0), .VID_MAX_WAIT(4)
        ) u_dut (
            .clk(clk), .reset(rst_a[g]),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]),
            .cpu_rdata(cpu_rdata[g]), .vid_req(vid_req[g]), .vid_addr(vid_addr[g]),
            .vid_gnt(vid_gnt[g]), .vid_rvalid(vid_rvalid[g]), .vid_rdata(vid_rdata[g]),
            .bram_addr(bram_addr[g]), .bram_wdata(bram_wdata[g]), .bram_we(bram_we[g]),
            .bram_q(bram_q[g])
        );

        // Write-first BRAM with LAT-cycle read pipeline.
        initial begin
            for (int a = 0; a < 65536; a++) mem[a] = 16'(a + g * 4096);
            for (int k = 0; k < 3; k++) qp[k] = 16'h0;
        end
        always @(posedge clk) begin
            if (bram_we[g]) mem[bram_addr[g]] <= bram_wdata[g];
            qp[0] <= bram_we[g] ? bram_wdata[g] : mem[bram_addr[g]];
            qp[1] <= qp[0];
            qp[2] <= qp[1];
        end
        assign bram_q[g] = qp[LAT-1];
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          inst;
        int          due;
        bit          vid;
        logic [15:0] data;
    } ev_t;

    ev_t         evq[$];
    logic [15:0] wlog[int];
    int          m_last [N];   // 0 none yet, 1 CPU, 2 video
    int          m_wait [N];

    function automatic int lat_of(int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic logic [15:0] mem_val(int i, logic [15:0] a);
        int key = i * 65536 + int'(a);
        if (wlog.exists(key)) return wlog[key];
        return 16'(int'(a) + i * 4096);
    endfunction

    task automatic model_cycle(int i);
        int          win;
        bit          e_cv, e_vv;
        logic [15:0] e_rd, e_addr;
        string       p;
        p    = $sformatf("m%0d ", i);
        e_cv = 1'b0;
        e_vv = 1'b0;
        e_rd = 16'h0;
        if (rst_a[i]) begin
            chk({p, "rst cpu_gnt"}, 32'(cpu_gnt[i]), 0);
            chk({p, "rst vid_gnt"}, 32'(vid_gnt[i]), 0);
            chk({p, "rst bram_we"}, 32'(bram_we[i]), 0);
            chk({p, "rst bram_addr"}, 32'(bram_addr[i]), 0);
            chk({p, "rst bram_wdata"}, 32'(bram_wdata[i]), 0);
            chk({p, "rst cpu_rvalid"}, 32'(cpu_rvalid[i]), 0);
            chk({p, "rst vid_rvalid"}, 32'(vid_rvalid[i]), 0);
            m_last[i] = 0;
            m_wait[i] = 0;
            for (int k = evq.size() - 1; k >= 0; k--)
                if (evq[k].inst == i) evq.delete(k);
            return;
        end
        if (cpu_req[i] && vid_req[i]) begin
            if (i == 1) win = (m_last[i] == 1) ? 2 : 1;
            else        win = (m_wait[i] == 4) ? 2 : 1;
        end else if (cpu_req[i]) win = 1;
        else if (vid_req[i])     win = 2;
        else                     win = 0;

        for (int k = evq.size() - 1; k >= 0; k--) begin
            if (evq[k].inst == i && evq[k].due == cyc) begin
                if (evq[k].vid) e_vv = 1'b1;
                else            e_cv = 1'b1;
                e_rd = evq[k].data;
                evq.delete(k);
            end
        end

        e_addr = (win == 1) ? cpu_addr[i] : ((win == 2) ? vid_addr[i] : 16'h0);
        chk({p, "cpu_gnt"}, 32'(cpu_gnt[i]), 32'(win == 1));
        chk({p, "vid_gnt"}, 32'(vid_gnt[i]), 32'(win == 2));
        chk({p, "bram_we"}, 32'(bram_we[i]), 32'(win == 1 && cpu_we[i]));
        chk({p, "bram_addr"}, 32'(bram_addr[i]), 32'(e_addr));
        chk({p, "bram_wdata"}, 32'(bram_wdata[i]), (win == 1) ? 32'(cpu_wdata[i]) : 0);
        chk({p, "cpu_rvalid"}, 32'(cpu_rvalid[i]), 32'(e_cv));
        chk({p, "vid_rvalid"}, 32'(vid_rvalid[i]), 32'(e_vv));
        if (e_cv) chk({p, "cpu_rdata"}, 32'(cpu_rdata[i]), 32'(e_rd));
        if (e_vv) chk({p, "vid_rdata"}, 32'(vid_rdata[i]), 32'(e_rd));

        if (!vid_req[i] || win == 2) m_wait[i] = 0;
        else if (win == 1 && m_wait[i] < 4) m_wait[i]++;
        if (win != 0) m_last[i] = win;
        if (win == 1 && cpu_we[i]) begin
            wlog[i * 65536 + int'(cpu_addr[i])] = cpu_wdata[i];
        end else if (win != 0) begin
            evq.push_back('{inst: i, due: cyc + lat_of(i), vid: (win == 2), data: mem_val(i, e_addr)});
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) model_cycle(i);
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic setc(int i, bit r, bit we, logic [15:0] a, logic [15:0] d);
        cpu_req[i] = r; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
    endtask
    task automatic setv(int i, bit r, logic [15:0] a);
        vid_req[i] = r; vid_addr[i] = a;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask

    logic [10:0] cg_vec, vg_vec;
    logic [6:0]  rv_vec, crv_vec;

    initial begin
        for (int i = 0; i < N; i++) begin
            rst_a[i] = 1'b1;
            setc(i, 0, 0, 16'h0, 16'h0);
            setv(i, 0, 16'h0);
        end
        // Reset state, with a write request already asserted on instance 0.
        setc(0, 1, 1, 16'h1234, 16'hFFFF);
        mid();
        chk("reset cpu_gnt", 32'(cpu_gnt[0]), 0);
        chk("reset bram_we", 32'(bram_we[0]), 0);
        chk("reset bram_addr", 32'(bram_addr[0]), 0);
        chk("reset bram_wdata", 32'(bram_wdata[0]), 0);
        step();
        for (int i = 0; i < N; i++) rst_a[i] = 1'b0;
        setc(0, 0, 0, 16'h0, 16'h0);
        mid(); step();

        // Test 1: write then read-back.
        setc(0, 1, 1, 16'h0010, 16'hBEEF);
        mid();
        chk("t1 write gnt", 32'(cpu_gnt[0]), 1);
        chk("t1 write we", 32'(bram_we[0]), 1);
        chk("t1 write data", 32'(bram_wdata[0]), 32'h0000BEEF);
        step();
        setc(0, 1, 0, 16'h0010, 16'h0);
        mid();
        chk("t1 read we", 32'(bram_we[0]), 0);
        chk("t1 no rvalid after write", 32'(cpu_rvalid[0]), 0);
        step();
        setc(0, 0, 0, 16'h0, 16'h0);
        mid();
        chk("t1 cpu_rvalid", 32'(cpu_rvalid[0]), 1);
        chk("t1 cpu_rdata", 32'(cpu_rdata[0]), 32'h0000BEEF);
        chk("t1 vid_rvalid", 32'(vid_rvalid[0]), 0);
        step();

        // Test 2: simultaneous single requests.
        setc(0, 1, 0, 16'h0020, 16'h0);
        setv(0, 1, 16'h0030);
        mid();
        chk("t2 c0 cpu_gnt", 32'(cpu_gnt[0]), 1);
        chk("t2 c0 vid_gnt", 32'(vid_gnt[0]), 0);
        step();
        setc(0, 0, 0, 16'h0, 16'h0);
        mid();
        chk("t2 c1 vid_gnt", 32'(vid_gnt[0]), 1);
        chk("t2 c1 cpu_rdata", 32'(cpu_rdata[0]), 32'h0020);
        step();
        setv(0, 0, 16'h0);
        mid();
        chk("t2 c2 vid_rvalid", 32'(vid_rvalid[0]), 1);
        chk("t2 c2 vid_rdata", 32'(vid_rdata[0]), 32'h0030);
        step();

        // Test 3: starvation guard.
        for (int k = 0; k < 11; k++) begin
            setc(0, 1, 0, 16'(16'h0400 + ((k < 4) ? k : k - 1)), 16'h0);
            setv(0, (k <= 4), 16'h0700);
            mid();
            cg_vec[k] = cpu_gnt[0];
            vg_vec[k] = vid_gnt[0];
            step();
        end
        setc(0, 0, 0, 16'h0, 16'h0);
        setv(0, 0, 16'h0);
        chk("t3 cpu grant pattern", 32'(cg_vec), 32'b11111101111);
        chk("t3 vid grant pattern", 32'(vg_vec), 32'b00000010000);
        mid(); step();

        // Test 4: round-robin alternation.
        for (int k = 0; k < 7; k++) begin
            setc(1, (k < 6), 0, 16'(16'h0500 + k / 2), 16'h0);
            setv(1, (k < 6), 16'(16'h0600 + k / 2));
            mid();
            if (k < 6) begin
                cg_vec[k] = cpu_gnt[1];
                vg_vec[k] = vid_gnt[1];
            end
            if (k > 0) begin
                crv_vec[k-1] = cpu_rvalid[1];
                rv_vec[k-1]  = vid_rvalid[1];
            end
            if (k == 2) chk("t4 vid_rdata", 32'(vid_rdata[1]), 32'h1600);
            step();
        end
        chk("t4 cpu grant pattern", 32'(cg_vec[5:0]), 32'b010101);
        chk("t4 vid grant pattern", 32'(vg_vec[5:0]), 32'b101010);
        chk("t4 cpu rvalid pattern", 32'(crv_vec[5:0]), 32'b010101);
        chk("t4 vid rvalid pattern", 32'(rv_vec[5:0]), 32'b101010);

        // Test 5: latency-3 back-to-back video reads.
        for (int k = 0; k < 7; k++) begin
            setv(2, (k < 3), 16'(16'h0100 + k));
            mid();
            rv_vec[k] = vid_rvalid[2];
            if (k >= 3 && k <= 5)
                chk("t5 vid_rdata", 32'(vid_rdata[2]), 32'(16'h2100 + k - 3));
            step();
        end
        chk("t5 vid rvalid pattern", 32'(rv_vec), 32'b0111000);

        // Test 6: reset with reads in flight and video about to be forced.
        for (int k = 0; k < 4; k++) begin
            setc(2, 1, 0, 16'(16'h0200 + k), 16'h0);
            setv(2, 1, 16'h0300);
            mid();
            chk("t6 cpu_gnt before reset", 32'(cpu_gnt[2]), 1);
            if (k == 3) chk("t6 cpu_rdata before reset", 32'(cpu_rdata[2]), 32'h2200);
            step();
        end
        rst_a[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mid();
            chk("t6 cpu_gnt in reset", 32'(cpu_gnt[2]), 0);
            chk("t6 vid_gnt in reset", 32'(vid_gnt[2]), 0);
            chk("t6 cpu_rvalid in reset", 32'(cpu_rvalid[2]), 0);
            step();
        end
        rst_a[2] = 1'b0;
        setc(2, 1, 0, 16'h0204, 16'h0);
        mid();
        chk("t6 first grant cpu", 32'(cpu_gnt[2]), 1);
        chk("t6 first grant addr", 32'(bram_addr[2]), 32'h0204);
        chk("t6 dropped rvalid", 32'(cpu_rvalid[2]), 0);
        step();
        setc(2, 0, 0, 16'h0, 16'h0);
        mid();
        chk("t6 vid after cpu", 32'(vid_gnt[2]), 1);
        step();
        setv(2, 0, 16'h0);
        for (int k = 0; k < 5; k++) begin
            mid(); step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
